// File: rtl/param_acc_datapath.sv
// Parametrised multicycle accumulator datapath.
// Holds PC, IR, DR, RESULT, an accumulator bank and C/Z/N flags. Every
// enable and select comes from the external control unit each cycle; the
// memory interface (address, read/write strobes, write data) is purely
// combinational from the current registers and selects.
module param_acc_datapath #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 13,
  parameter int OPC_W   = 3,
  parameter int NUM_ACC = 4,
  localparam int AW     = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_en,
  input  logic              sel_pc,
  input  logic [1:0]        sel_address,
  input  logic              mr,
  input  logic              mw,
  input  logic              ir_hi_en,
  input  logic              ir_lo_en,
  input  logic              dr_en,
  input  logic [AW-1:0]     acc_sel,
  input  logic              acc_we,
  input  logic [1:0]        sel_data,
  input  logic              sel_alu_src,
  input  logic [2:0]        alu_op,
  input  logic              result_en,
  input  logic              c_en,
  input  logic              z_en,
  input  logic              n_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [OPC_W-1:0]  opcode,
  output logic              flag_c,
  output logic              flag_z,
  output logic              flag_n,
  output logic [ADDR_W-1:0] pc
);

  localparam int IR_W = 2 * DATA_W;

  logic [DATA_W-1:0] ir_hi;
  logic [DATA_W-1:0] ir_lo;
  logic [DATA_W-1:0] dr;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] acc [NUM_ACC];

  logic [IR_W-1:0]   ir;
  logic [ADDR_W-1:0] ir_addr;
  logic [ADDR_W-1:0] ind_addr;
  logic [DATA_W-1:0] acc_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_out;
  logic              alu_c;
  logic              alu_z;
  logic              alu_n;
  logic [DATA_W-1:0] wr_data;

  // ALU: returns {carry, result}. SUB is A + ~B + 1, so carry=1 means no borrow.
  function automatic logic [DATA_W:0] alu_calc(input logic [2:0]        op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic [DATA_W:0] r;
    case (op)
      3'b000:  r = {1'b0, a} + {1'b0, b};
      3'b001:  r = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
      3'b010:  r = {1'b0, a & b};
      3'b011:  r = {1'b0, a | b};
      3'b100:  r = {1'b0, ~a};
      3'b101:  r = {1'b0, b};
      3'b110:  r = {a[DATA_W-1], a << 1};
      default: r = {a[0], a >> 1};
    endcase
    return r;
  endfunction

  assign ir      = {ir_hi, ir_lo};
  assign ir_addr = ir[ADDR_W-1:0];
  assign opcode  = ir[IR_W-1 -: OPC_W];

  // Accumulator read port shared by ALU operand A, write data and indirect address.
  always_comb begin
    acc_a = '0;
    for (int i = 0; i < NUM_ACC; i++) begin
      if (acc_sel == AW'(i)) acc_a = acc[i];
    end
  end

  // Indirect address: accumulator zero-extended or truncated to the address width.
  always_comb begin
    ind_addr = '0;
    for (int i = 0; i < ADDR_W && i < DATA_W; i++) begin
      ind_addr[i] = acc_a[i];
    end
  end

  // ALU operand select and flag derivation.
  always_comb begin
    alu_b                   = sel_alu_src ? ir_lo : dr;
    {alu_c, alu_out}        = alu_calc(alu_op, acc_a, alu_b);
    alu_z                   = (alu_out == '0);
    alu_n                   = alu_out[DATA_W-1];
  end

  // Accumulator write source select.
  always_comb begin
    case (sel_data)
      2'd0:    wr_data = result;
      2'd1:    wr_data = dr;
      2'd2:    wr_data = '0;
      default: wr_data = ir_lo;
    endcase
  end

  // Memory address source select; zero latency from select to address.
  always_comb begin
    case (sel_address)
      2'd1:    mem_addr = ir_addr;
      2'd2:    mem_addr = ind_addr;
      default: mem_addr = pc;
    endcase
  end

  assign mem_rd    = mr & reset;
  assign mem_wr    = mw & reset;
  assign mem_wdata = acc_a;

  // PC, IR, DR and RESULT registers; reset overrides every enable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc     <= '0;
      ir_hi  <= '0;
      ir_lo  <= '0;
      dr     <= '0;
      result <= '0;
    end else begin
      if (pc_en)     pc     <= sel_pc ? ir_addr : pc + ADDR_W'(1);
      if (ir_hi_en)  ir_hi  <= mem_rdata;
      if (ir_lo_en)  ir_lo  <= mem_rdata;
      if (dr_en)     dr     <= mem_rdata;
      if (result_en) result <= alu_out;
    end
  end

  // Flags load individually from the ALU, independent of result_en.
  always_ff @(posedge clk) begin
    if (!reset) begin
      flag_c <= 1'b0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else begin
      if (c_en) flag_c <= alu_c;
      if (z_en) flag_z <= alu_z;
      if (n_en) flag_n <= alu_n;
    end
  end

  // Accumulator bank: only the selected entry is written.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ACC; i++) acc[i] <= '0;
    end else if (acc_we) begin
      for (int i = 0; i < NUM_ACC; i++) begin
        if (acc_sel == AW'(i)) acc[i] <= wr_data;
      end
    end
  end

endmodule
